// File: rtl/timestamp_sequencer.sv
// timestamp_sequencer: timestamp counter with IDLE/ARMED/RUNNING sequencing, offset load and trigger auto-start
module timestamp_sequencer #(
  parameter int TS_WIDTH    = 64,
  parameter int COUNT_STEP  = 1,
  parameter int ARM_TIMEOUT = 0,
  parameter int TO_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                offset_en,
  input  logic [TS_WIDTH-1:0] counter_offset,
  input  logic                auto_start,
  input  logic                ext_trigger,
  output logic [TS_WIDTH-1:0] timestamp,
  output logic                running,
  output logic                armed,
  output logic                start_pulse,
  output logic                overflow,
  output logic                arm_timeout
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUNNING = 2'd2} state_t;
  localparam logic [TS_WIDTH-1:0] STEP    = TS_WIDTH'(COUNT_STEP);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(ARM_TIMEOUT - 1);
  state_t              r_state;
  logic                r_start_d;
  logic                r_offset_en_d;
  logic [TO_WIDTH-1:0] r_to_cnt;
  logic                w_start_rise;
  logic                w_start_fall;
  logic                w_offset_rise;
  logic [TS_WIDTH:0]   w_sum;
  assign w_start_rise  = start & ~r_start_d;
  assign w_start_fall  = ~start & r_start_d;
  assign w_offset_rise = offset_en & ~r_offset_en_d;
  assign w_sum         = {1'b0, timestamp} + {1'b0, STEP};
  assign running       = r_state == RUNNING;
  assign armed         = r_state == ARMED;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      timestamp     <= '0;
      overflow      <= 1'b0;
      arm_timeout   <= 1'b0;
      start_pulse   <= 1'b0;
      r_start_d     <= start;
      r_offset_en_d <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_start_d     <= start;
      r_offset_en_d <= offset_en;
      start_pulse   <= 1'b0;
      case (r_state)
        IDLE: if (w_start_rise) begin
          arm_timeout <= 1'b0;
          if (auto_start) begin
            r_state  <= ARMED;
            r_to_cnt <= '0;
          end else begin
            r_state     <= RUNNING;
            start_pulse <= 1'b1;
          end
        end
        ARMED: if (w_start_fall) r_state <= IDLE;
          else if (ext_trigger) begin
            r_state     <= RUNNING;
            start_pulse <= 1'b1;
          end else if (ARM_TIMEOUT != 0 && r_to_cnt == TO_LAST) begin
            r_state     <= IDLE;
            arm_timeout <= 1'b1;
          end else r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
        RUNNING: if (w_start_fall) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      // an offset load overrides the same-cycle increment and restarts overflow tracking
      if (w_offset_rise) begin
        timestamp <= counter_offset;
        overflow  <= 1'b0;
      end else if (r_state == RUNNING) begin
        timestamp <= w_sum[TS_WIDTH-1:0];
        if (w_sum[TS_WIDTH]) overflow <= 1'b1;
      end
    end
  end
endmodule
